// File: rtl/ram_arbiter_if.sv
// Bus bundle between the CPU ports, the arbiter and the shared RAM.
// slave is the arbiter's view; master is the CPUs-plus-RAM side.
interface ram_arbiter_if #(
  parameter int CPUS = 2
);
  logic [CPUS-1:0]    iREN;
  logic [CPUS-1:0]    dREN;
  logic [CPUS-1:0]    dWEN;
  logic [CPUS*32-1:0] iaddr;
  logic [CPUS*32-1:0] daddr;
  logic [CPUS*32-1:0] dstore;
  logic [CPUS-1:0]    iwait;
  logic [CPUS-1:0]    dwait;
  logic [CPUS*32-1:0] iload;
  logic [CPUS*32-1:0] dload;
  logic [1:0]         ramstate;
  logic [31:0]        ramload;
  logic [31:0]        ramaddr;
  logic [31:0]        ramstore;
  logic               ramREN;
  logic               ramWEN;

  modport slave (
    input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramstate, ramload,
    output iwait, dwait, iload, dload, ramaddr, ramstore, ramREN, ramWEN
  );

  modport master (
    output iREN, dREN, dWEN, iaddr, daddr, dstore, ramstate, ramload,
    input  iwait, dwait, iload, dload, ramaddr, ramstore, ramREN, ramWEN
  );
endinterface

// File: rtl/ram_arbiter.sv
// Shares one RAM port among CPUS instruction/data ports: data first, round-robin per class.
// Optional instruction anti-starvation enabled by defining MEM_ARB_ISTARVE_EN.
module ram_arbiter #(
  parameter int CPUS         = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          CLK,
  input  logic          nRST,
  ram_arbiter_if.slave  bus
);
  localparam int PW = (CPUS > 1) ? $clog2(CPUS) : 1;
  // ramstate encoding: FREE=0, BUSY=1, ACCESS=2, ERROR=3
  localparam logic [1:0] ACCESS = 2'd2;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t          state_reg;
  logic            lock_is_d_reg;
  logic [PW-1:0]   lock_idx_reg;
  logic [PW-1:0]   iptr_reg;
  logic [PW-1:0]   dptr_reg;

  logic [CPUS-1:0] dreq;
  logic            d_found, i_found, prefer_i;
  logic [PW-1:0]   d_sel, i_sel;
  logic            g_valid, g_is_d, done;
  logic [PW-1:0]   g_idx;

  assign dreq = bus.dREN | bus.dWEN;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (int'(p) >= CPUS - 1) ? PW'(0) : p + 1'b1;
  endfunction

  always_comb begin
    int jd, ji;
    d_found = 1'b0;
    i_found = 1'b0;
    d_sel   = '0;
    i_sel   = '0;
    for (int off = 0; off < CPUS; off++) begin
      jd = (int'(dptr_reg) + off) % CPUS;
      ji = (int'(iptr_reg) + off) % CPUS;
      if (!d_found && dreq[PW'(jd)]) begin
        d_found = 1'b1;
        d_sel   = PW'(jd);
      end
      if (!i_found && bus.iREN[PW'(ji)]) begin
        i_found = 1'b1;
        i_sel   = PW'(ji);
      end
    end
  end

`ifdef MEM_ARB_ISTARVE_EN
  localparam int CW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;
  logic [CW-1:0] starve_cnt_reg;
  assign prefer_i = i_found && (starve_cnt_reg == CW'(STARVE_LIMIT));
`else
  assign prefer_i = 1'b0;
`endif

  // In LOCK the grant is frozen; it lapses only if its owner withdraws the request.
  always_comb begin
    g_valid = 1'b0;
    g_is_d  = 1'b0;
    g_idx   = '0;
    if (state_reg == LOCK) begin
      g_is_d  = lock_is_d_reg;
      g_idx   = lock_idx_reg;
      g_valid = lock_is_d_reg ? dreq[lock_idx_reg] : bus.iREN[lock_idx_reg];
    end else if (d_found && !prefer_i) begin
      g_valid = 1'b1;
      g_is_d  = 1'b1;
      g_idx   = d_sel;
    end else if (i_found) begin
      g_valid = 1'b1;
      g_idx   = i_sel;
    end
    if (!nRST)
      g_valid = 1'b0;
  end

  assign done = g_valid && (bus.ramstate == ACCESS);

  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    if (g_valid) begin
      if (g_is_d) begin
        bus.ramaddr = bus.daddr[32*int'(g_idx) +: 32];
        if (bus.dWEN[g_idx]) begin
          bus.ramWEN   = 1'b1;
          bus.ramstore = bus.dstore[32*int'(g_idx) +: 32];
        end else begin
          bus.ramREN = 1'b1;
        end
      end else begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = bus.iaddr[32*int'(g_idx) +: 32];
      end
    end
  end

  for (genvar gi = 0; gi < CPUS; gi++) begin : g_cpu
    logic i_hit, d_hit;
    assign d_hit = done &&  g_is_d && (g_idx == PW'(gi));
    assign i_hit = done && !g_is_d && (g_idx == PW'(gi));
    assign bus.dwait[gi]           = !d_hit;
    assign bus.iwait[gi]           = !i_hit;
    assign bus.dload[32*gi +: 32]  = d_hit ? bus.ramload : 32'h0;
    assign bus.iload[32*gi +: 32]  = i_hit ? bus.ramload : 32'h0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg      <= IDLE;
      lock_is_d_reg  <= 1'b0;
      lock_idx_reg   <= '0;
      iptr_reg       <= '0;
      dptr_reg       <= '0;
`ifdef MEM_ARB_ISTARVE_EN
      starve_cnt_reg <= '0;
`endif
    end else begin
      if (done) begin
        state_reg <= IDLE;
        if (g_is_d)
          dptr_reg <= ptr_inc(g_idx);
        else
          iptr_reg <= ptr_inc(g_idx);
      end else if (g_valid) begin
        state_reg     <= LOCK;
        lock_is_d_reg <= g_is_d;
        lock_idx_reg  <= g_idx;
      end else begin
        state_reg <= IDLE;
      end
`ifdef MEM_ARB_ISTARVE_EN
      if (!(|bus.iREN))
        starve_cnt_reg <= '0;
      else if (done) begin
        if (!g_is_d)
          starve_cnt_reg <= '0;
        else if (starve_cnt_reg != CW'(STARVE_LIMIT))
          starve_cnt_reg <= starve_cnt_reg + 1'b1;
      end
`endif
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with CPUS=2: vector table plus reset and priority sequences.
module tb_ram_arbiter;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  typedef struct packed {
    logic [1:0]  iren, dren, dwen, rs;
    logic [1:0]  e_iwait, e_dwait;
    logic        e_ren, e_wen;
    logic [31:0] e_addr, e_store;
  } vec_t;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tbl [19];

  ram_arbiter_if #(.CPUS(2)) bus ();

  ram_arbiter #(.CPUS(2), .STARVE_LIMIT(4)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic cmp(input string tag, input string field, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %h, want %h", tag, field, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [1:0] e_iw, input logic [1:0] e_dw,
                           input logic e_ren, input logic e_wen,
                           input logic [31:0] e_addr, input logic [31:0] e_store);
    logic [31:0] load0, load1;
    $display("%s: iREN=%b dREN=%b dWEN=%b rs=%0d -> iwait=%b dwait=%b REN=%b WEN=%b addr=%h store=%h",
             tag, bus.iREN, bus.dREN, bus.dWEN, bus.ramstate, bus.iwait, bus.dwait,
             bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore);
    cmp(tag, "iwait", 32'(bus.iwait), 32'(e_iw));
    cmp(tag, "dwait", 32'(bus.dwait), 32'(e_dw));
    cmp(tag, "ramREN", 32'(bus.ramREN), 32'(e_ren));
    cmp(tag, "ramWEN", 32'(bus.ramWEN), 32'(e_wen));
    cmp(tag, "ramaddr", bus.ramaddr, e_addr);
    cmp(tag, "ramstore", bus.ramstore, e_store);
    load0 = e_iw[0] ? 32'h0 : bus.ramload;
    load1 = e_iw[1] ? 32'h0 : bus.ramload;
    cmp(tag, "iload0", bus.iload[31:0], load0);
    cmp(tag, "iload1", bus.iload[63:32], load1);
    load0 = e_dw[0] ? 32'h0 : bus.ramload;
    load1 = e_dw[1] ? 32'h0 : bus.ramload;
    cmp(tag, "dload0", bus.dload[31:0], load0);
    cmp(tag, "dload1", bus.dload[63:32], load1);
  endtask

  task automatic drive(input logic [1:0] iren, input logic [1:0] dren, input logic [1:0] dwen,
                       input logic [1:0] rs, input logic [31:0] load);
    bus.iREN     = iren;
    bus.dREN     = dren;
    bus.dWEN     = dwen;
    bus.ramstate = rs;
    bus.ramload  = load;
  endtask

  initial begin
    bus.iaddr  = {32'h0000_1004, 32'h0000_1000};
    bus.daddr  = {32'h0000_0040, 32'h0000_0020};
    bus.dstore = {32'hDEAD_BEEF, 32'hCAFE_F00D};
    drive(2'b11, 2'b11, 2'b01, ACCESS, 32'h1111_2222);

    // Reset held with requests present: everything must be quiet.
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_out("reset", 2'b11, 2'b11, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge CLK);
    #1 nRST = 1'b1;

    //             iren   dren   dwen   rs      iwait  dwait  ren   wen   addr          store
    tbl[0]  = '{2'b00, 2'b00, 2'b00, ACCESS, 2'b11, 2'b11, 1'b0, 1'b0, 32'h0,        32'h0};
    tbl[1]  = '{2'b11, 2'b00, 2'b00, ACCESS, 2'b10, 2'b11, 1'b1, 1'b0, 32'h1000,     32'h0};
    tbl[2]  = '{2'b11, 2'b00, 2'b00, ACCESS, 2'b01, 2'b11, 1'b1, 1'b0, 32'h1004,     32'h0};
    tbl[3]  = '{2'b11, 2'b00, 2'b00, ACCESS, 2'b10, 2'b11, 1'b1, 1'b0, 32'h1000,     32'h0};
    tbl[4]  = '{2'b01, 2'b00, 2'b10, BUSY,   2'b11, 2'b11, 1'b0, 1'b1, 32'h40,       32'hDEADBEEF};
    tbl[5]  = '{2'b01, 2'b00, 2'b10, BUSY,   2'b11, 2'b11, 1'b0, 1'b1, 32'h40,       32'hDEADBEEF};
    tbl[6]  = '{2'b01, 2'b00, 2'b10, BUSY,   2'b11, 2'b11, 1'b0, 1'b1, 32'h40,       32'hDEADBEEF};
    tbl[7]  = '{2'b01, 2'b00, 2'b10, ACCESS, 2'b11, 2'b01, 1'b0, 1'b1, 32'h40,       32'hDEADBEEF};
    tbl[8]  = '{2'b01, 2'b00, 2'b00, ACCESS, 2'b10, 2'b11, 1'b1, 1'b0, 32'h1000,     32'h0};
    tbl[9]  = '{2'b01, 2'b00, 2'b00, BUSY,   2'b11, 2'b11, 1'b1, 1'b0, 32'h1000,     32'h0};
    tbl[10] = '{2'b01, 2'b10, 2'b00, BUSY,   2'b11, 2'b11, 1'b1, 1'b0, 32'h1000,     32'h0};
    tbl[11] = '{2'b01, 2'b10, 2'b00, ACCESS, 2'b10, 2'b11, 1'b1, 1'b0, 32'h1000,     32'h0};
    tbl[12] = '{2'b01, 2'b10, 2'b00, ACCESS, 2'b11, 2'b01, 1'b1, 1'b0, 32'h40,       32'h0};
    tbl[13] = '{2'b00, 2'b01, 2'b00, BUSY,   2'b11, 2'b11, 1'b1, 1'b0, 32'h20,       32'h0};
    tbl[14] = '{2'b00, 2'b00, 2'b00, BUSY,   2'b11, 2'b11, 1'b0, 1'b0, 32'h0,        32'h0};
    tbl[15] = '{2'b00, 2'b11, 2'b00, ACCESS, 2'b11, 2'b10, 1'b1, 1'b0, 32'h20,       32'h0};
    tbl[16] = '{2'b00, 2'b11, 2'b00, ACCESS, 2'b11, 2'b01, 1'b1, 1'b0, 32'h40,       32'h0};
    tbl[17] = '{2'b00, 2'b10, 2'b10, ERROR,  2'b11, 2'b11, 1'b0, 1'b1, 32'h40,       32'hDEADBEEF};
    tbl[18] = '{2'b00, 2'b10, 2'b10, ACCESS, 2'b11, 2'b01, 1'b0, 1'b1, 32'h40,       32'hDEADBEEF};

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].iren, tbl[i].dren, tbl[i].dwen, tbl[i].rs, 32'h5A00_0000 | 32'(i));
      @(negedge CLK);
      check_out($sformatf("vec%0d", i), tbl[i].e_iwait, tbl[i].e_dwait, tbl[i].e_ren,
                tbl[i].e_wen, tbl[i].e_addr, tbl[i].e_store);
      @(posedge CLK);
      #1;
    end

    // Reset during LOCK: pointer advanced to CPU1 beforehand, reset must restore CPU0 first.
    drive(2'b00, 2'b01, 2'b00, ACCESS, 32'h7700_0001);
    @(negedge CLK);
    check_out("rst_pre", 2'b11, 2'b10, 1'b1, 1'b0, 32'h20, 32'h0);
    @(posedge CLK);
    #1 drive(2'b00, 2'b11, 2'b00, BUSY, 32'h7700_0002);
    @(negedge CLK);
    check_out("rst_lock", 2'b11, 2'b11, 1'b1, 1'b0, 32'h40, 32'h0);
    @(posedge CLK);
    #2 nRST = 1'b0;
    bus.ramstate = ACCESS;
    #1 check_out("rst_mid", 2'b11, 2'b11, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge CLK);
    #1 nRST = 1'b1;
    drive(2'b00, 2'b11, 2'b00, ACCESS, 32'h7700_0003);
    @(negedge CLK);
    check_out("rst_after", 2'b11, 2'b10, 1'b1, 1'b0, 32'h20, 32'h0);
    @(posedge CLK);
    #1;

    // Continuous data plus one instruction requester, RAM always ready.
    for (int c = 0; c < 7; c++) begin
      logic inst_turn;
`ifdef MEM_ARB_ISTARVE_EN
      inst_turn = (c == 4);
`else
      inst_turn = 1'b0;
`endif
      drive(2'b01, 2'b01, 2'b00, ACCESS, 32'h3300_0000 | 32'(c));
      @(negedge CLK);
      if (inst_turn)
        check_out($sformatf("starve%0d", c), 2'b10, 2'b11, 1'b1, 1'b0, 32'h1000, 32'h0);
      else
        check_out($sformatf("starve%0d", c), 2'b11, 2'b10, 1'b1, 1'b0, 32'h20, 32'h0);
      @(posedge CLK);
      #1;
    end

    drive(2'b00, 2'b00, 2'b00, FREE, 32'h0);
    @(negedge CLK);
    check_out("idle_end", 2'b11, 2'b11, 1'b0, 1'b0, 32'h0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter CPUS, default 2, number of CPU ports (1..8).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, consecutive data grants before instruction priority (used only under REQ-030).
REQ-003 SHALL have port CLK  in  1  clock, rising edge.
REQ-004 SHALL have port nRST  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports iREN / dREN / dWEN  in  CPUS each  per-CPU instruction read / data read / data write requests.
REQ-006 SHALL have ports iaddr / daddr / dstore  in  CPUS*32 each  per-CPU addresses and write data, CPU k at bits [32k+31:32k].
REQ-007 SHALL have ports iwait / dwait  out  CPUS each  per-CPU stall; 0 means transfer completes this cycle.
REQ-008 SHALL have ports iload / dload  out  CPUS*32 each  per-CPU read data.
REQ-009 SHALL have ports ramstate  in  2 (FREE, BUSY, ACCESS, ERROR per cpu_types_pkg) and ramload  in  32.
REQ-010 SHALL have ports ramaddr, ramstore  out  32 each and ramREN, ramWEN  out  1 each.

Function
REQ-011 SHALL implement FSM states IDLE and LOCK; a grant is {type I/D, index}.
REQ-012 In IDLE, SHALL select data requesters (dREN|dWEN) before instruction requesters, round-robin within each class starting at that class's pointer.
REQ-013 In IDLE, SHALL drive the RAM from the selected request in the same cycle (zero arbitration latency).
REQ-014 If ramstate != ACCESS with a grant active in IDLE, SHALL register the grant and enter LOCK.
REQ-015 In LOCK, SHALL drive the RAM only from the locked grant, ignoring new or higher-priority requests.
REQ-016 When ramstate == ACCESS, SHALL drive the granted CPU's wait low and its load = ramload for that cycle, advance that class pointer to index+1 (wrap CPUS-1 -> 0), and enter or stay in IDLE.
REQ-017 If the locked requester drops its request before ACCESS, SHALL deassert RAM enables, leave its wait high, leave pointers unchanged, and return to IDLE next cycle.
REQ-018 A data grant with dWEN=1 SHALL assert ramWEN=1 and ramstore = dstore[k], with ramREN=0 (write wins over dREN).
REQ-019 A data read SHALL assert ramREN=1 and ramaddr = daddr[k]; an instruction grant SHALL assert ramREN=1 and ramaddr = iaddr[k].
REQ-020 ramstate ERROR or BUSY SHALL be treated as not complete; the grant is held.
REQ-021 Non-granted CPUs SHALL see wait=1 and load=0; with no grant, ramREN = ramWEN = 0 and ramaddr = ramstore = 0.
REQ-022 At most one wait bit across iwait and dwait SHALL be low in any cycle.
REQ-023 Pointer width SHALL be max(1, clog2(CPUS)); with CPUS=1, pointers SHALL stay 0.

Reset
REQ-024 nRST low SHALL asynchronously force IDLE, both pointers 0, and the starvation counter 0.
REQ-025 During reset, outputs SHALL be: iwait and dwait all 1, iload and dload 0, RAM enables, ramaddr and ramstore 0.
REQ-026 Reset asserted mid-transfer SHALL abort the transfer; after release, arbitration restarts fresh from IDLE.

Configuration
REQ-030 With macro MEM_ARB_ISTARVE_EN defined, SHALL count data completions that occur while any iREN is high, clearing the count on an instruction completion or when no iREN is high.
REQ-031 With MEM_ARB_ISTARVE_EN defined and count == STARVE_LIMIT, the next IDLE selection SHALL pick instruction before data.
REQ-032 Without MEM_ARB_ISTARVE_EN, SHALL use strict data priority, and the counter logic SHALL be absent.

Verification
REQ-040 CPUS=2; iREN=2'b11; ramstate ACCESS every cycle -> iwait low alternates CPU0, CPU1, CPU0, and iload equals ramload.
REQ-041 dWEN[1]=1, daddr[1]=0x40, dstore[1]=0xDEADBEEF, iREN[0]=1; ramstate BUSY 3 cycles then ACCESS -> ramWEN=1 for 4 cycles, ramaddr=0x40, dwait[1] low only on cycle 4, iwait[0] stays high.
REQ-042 While LOCK on an I-grant for CPU0, assert dREN[1] -> the grant is unchanged until ACCESS, then the data grant is taken next cycle.
REQ-043 LOCK on dREN[0]; drop dREN[0] before ACCESS -> RAM enables 0 next cycle, dwait[0] stays high, the data pointer stays 0.
REQ-044 nRST pulsed low during LOCK -> all outputs reach reset values immediately, and a pending request is re-arbitrated after release.
REQ-045 MEM_ARB_ISTARVE_EN defined, STARVE_LIMIT=4, dREN continuous, iREN[0]=1, ACCESS every cycle -> 4 data completions, then one iwait[0] low, then data resumes.
